// File: rtl/flex_down_counter_if.sv
// ============================================================================
// Module      : flex_down_counter_if
// Description : Control/status bundle for flex_down_counter. The master side
//               drives clear/load/load_val/count_enable/periodic; the slave
//               side (the counter) returns count_out/expire_flag/busy.
//               Optional macro: FLEX_DOWN_COUNTER_EXPIRE_CNT_EN adds expire_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface flex_down_counter_if #(
  parameter int NUM_CNT_BITS = 4
);
  logic                    clear;
  logic                    load;
  logic [NUM_CNT_BITS-1:0] load_val;
  logic                    count_enable;
  logic                    periodic;
  logic [NUM_CNT_BITS-1:0] count_out;
  logic                    expire_flag;
  logic                    busy;
`ifdef FLEX_DOWN_COUNTER_EXPIRE_CNT_EN
  logic [7:0]              expire_cnt;
`endif

`ifdef FLEX_DOWN_COUNTER_EXPIRE_CNT_EN
  modport master (
    output clear, load, load_val, count_enable, periodic,
    input  count_out, expire_flag, busy, expire_cnt
  );
  modport slave (
    input  clear, load, load_val, count_enable, periodic,
    output count_out, expire_flag, busy, expire_cnt
  );
`else
  modport master (
    output clear, load, load_val, count_enable, periodic,
    input  count_out, expire_flag, busy
  );
  modport slave (
    input  clear, load, load_val, count_enable, periodic,
    output count_out, expire_flag, busy
  );
`endif
endinterface

`default_nettype wire

// File: rtl/flex_down_counter.sv
// ============================================================================
// Module      : flex_down_counter
// Description : Loadable down-counter. Counts from the reload value down to 1,
//               flags expiry while the count sits at 1, then reloads
//               (periodic) or halts at 0 (one-shot). All outputs registered.
//               Optional macro: FLEX_DOWN_COUNTER_EXPIRE_CNT_EN adds a
//               saturating 8-bit expiry-event counter (expire_cnt).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module flex_down_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  wire logic              clk,
  input  wire logic              rst,
  flex_down_counter_if.slave     bus
);

  localparam logic [0:0] c_st_idle = 1'b0;
  localparam logic [0:0] c_st_run  = 1'b1;
  localparam logic [NUM_CNT_BITS-1:0] c_one  = NUM_CNT_BITS'(1);
  localparam logic [NUM_CNT_BITS-1:0] c_zero = '0;

  logic [0:0]              r_state;
  logic [NUM_CNT_BITS-1:0] r_count;
  logic [NUM_CNT_BITS-1:0] r_reload;
  logic                    r_expire;
  logic                    r_busy;

  logic [0:0]              w_state;
  logic [NUM_CNT_BITS-1:0] w_count;
  logic [NUM_CNT_BITS-1:0] w_reload;
  logic                    w_expire_step;

  // Next-state decode in priority order: clear > load > count_enable > hold.
  always_comb begin
    w_state       = r_state;
    w_count       = r_count;
    w_reload      = r_reload;
    w_expire_step = 1'b0;
    if (bus.clear) begin
      w_count = c_zero;
      w_state = c_st_idle;
    end else if (bus.load) begin
      // A zero load value is a cancel: nothing to count toward.
      w_reload = bus.load_val;
      w_count  = bus.load_val;
      w_state  = (bus.load_val != c_zero) ? c_st_run : c_st_idle;
    end else if (bus.count_enable && (r_state == c_st_run)) begin
      if (r_count == c_one) begin
        w_expire_step = 1'b1;
        if (bus.periodic) begin
          w_count = r_reload;
        end else begin
          w_count = c_zero;
          w_state = c_st_idle;
        end
      end else begin
        w_count = r_count - c_one;
      end
    end
  end

  // Register state, count, reload value and the derived status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= c_st_idle;
      r_count  <= c_zero;
      r_reload <= c_zero;
      r_expire <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_count  <= w_count;
      r_reload <= w_reload;
      r_expire <= (w_state == c_st_run) && (w_count == c_one);
      r_busy   <= (w_state == c_st_run);
    end
  end

  assign bus.count_out   = r_count;
  assign bus.expire_flag = r_expire;
  assign bus.busy        = r_busy;

`ifdef FLEX_DOWN_COUNTER_EXPIRE_CNT_EN
  logic [7:0] r_expire_cnt;

  // Count expiry events, saturating at 255; load leaves the tally alone.
  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      r_expire_cnt <= 8'd0;
    end else if (w_expire_step && (r_expire_cnt != 8'hFF)) begin
      r_expire_cnt <= r_expire_cnt + 8'd1;
    end
  end

  assign bus.expire_cnt = r_expire_cnt;
`endif

endmodule

`default_nettype wire
